demux_j: RTL and testbench
==========================

DEMUX_J -- requirements
Module: demux_j

Interface
REQ-001 Parameter N, default 32, data word width in bits.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on Clock rising edge.
REQ-004 InValid  input  1  upstream word present on InData/Select.
REQ-005 InReady  output  1  block accepts word this cycle.
REQ-006 InData  input  N  word to route.
REQ-007 Select  input  2  destination: 0 -> port 1, 1 -> port 2, 2 -> port 3, 3 illegal.
REQ-008 Output1/Output2/Output3  output  N each  held word per destination.
REQ-009 OutValid  output  3  bit k-1 = Outputk holds valid word.
REQ-010 OutReady  input  3  bit k-1 = consumer k takes word this cycle.
REQ-011 Error  output  1  sticky illegal-select flag (see Configuration).

Function
REQ-012 Transfer in = InValid & InReady; transfer out k = OutValid[k-1] & OutReady[k-1], both at Clock rising edge.
REQ-013 Each destination SHALL own one holding register (data + valid bit); no other storage.
REQ-014 InReady SHALL be combinational: 1 when Select==3, else (!OutValid[s] | OutReady[s]) for selected s; independent of InValid.
REQ-015 Latency SHALL be exactly one cycle: word accepted at edge t appears on Outputk with OutValid set after edge t.
REQ-016 Simultaneous drain and fill of the same destination SHALL replace data with no bubble (full throughput, one word/cycle).
REQ-017 A held word SHALL stay stable (data and valid) until its out transfer; non-selected destinations SHALL be unaffected by in transfers.
REQ-018 OutValid[k-1] clears on out transfer without same-cycle refill; otherwise unchanged.
REQ-019 Independent destinations SHALL drain concurrently in the same cycle.
REQ-020 Select==3 with InValid SHALL be accepted and discarded; no OutValid change.
REQ-021 Output data register contents when OutValid=0 are don't-care but SHALL not glitch X into OutValid.

Reset
REQ-022 Reset=1 at an edge SHALL clear OutValid to 3'b000, Outputk to 0, Error to 0, overriding any same-cycle transfer.
REQ-023 Reset mid-operation SHALL drop all held words; InReady SHALL be 1 in the first cycle after reset for all Select.
REQ-024 Reset has priority over every other state update; no state changes without a Clock edge.

Configuration
REQ-025 Macro DEMUX_J_ERROR_EN SHALL select illegal-select reporting.
REQ-026 With DEMUX_J_ERROR_EN defined: in transfer with Select==3 sets Error at next edge; Error stays 1 until Reset.
REQ-027 Without DEMUX_J_ERROR_EN: Error port SHALL remain present and constant 0; illegal words still silently discarded.

Verification
REQ-028 Reset, then InValid=1, Select=1, InData=32'hDEADBEEF, OutReady=3'b000 -> next cycle OutValid=3'b010, Output2=32'hDEADBEEF, others 0.
REQ-029 Port 1 full, OutReady=3'b000, Select=0, InValid=1 -> InReady=0 for 5 cycles, Output1 unchanged; raise OutReady[0] -> InReady=1 same cycle, new word next cycle.
REQ-030 Back-to-back Select=2, data 1..8, OutReady[2]=1 -> Output3 shows 1..8 on 8 consecutive cycles, OutValid[2] continuously 1.
REQ-031 Select=3, InValid=1, data 32'h12345678 -> InReady=1, OutValid unchanged; Error=1 next cycle with macro, Error=0 without.
REQ-032 All three ports full, Reset asserted with InValid=1 and OutReady=3'b111 -> after edge OutValid=0, Error=0, all Outputs 0.
REQ-033 Ports 1 and 3 full, OutReady=3'b101, new word Select=0 -> port 3 drains, port 1 replaced same edge, OutValid=3'b001.

Source files
------------

// File: rtl/demux_j.sv
// rtl/demux_j.sv - 1-to-3 valid/ready demultiplexer, one holding register per destination
// Optional sticky illegal-select reporting enabled by defining DEMUX_J_ERROR_EN
module demux_j #(
    parameter int N = 32
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [N-1:0] InData,
    input  logic [1:0]   Select,
    output logic [N-1:0] Output1,
    output logic [N-1:0] Output2,
    output logic [N-1:0] Output3,
    output logic [2:0]   OutValid,
    input  logic [2:0]   OutReady,
    output logic         Error
);

    logic [N-1:0] data_q [3];
    logic [N-1:0] data_d [3];
    logic [2:0]   valid_q;
    logic [2:0]   valid_d;
    logic [3:0]   busy;
    logic         in_xfer;

    // Bit 3 of busy is tied low so the illegal select is always ready.
    assign busy = {1'b0, valid_q & ~OutReady};

    always_comb begin
        InReady = !busy[Select];
        in_xfer = InValid && InReady;
        for (int k = 0; k < 3; k++) begin
            data_d[k]  = data_q[k];
            valid_d[k] = valid_q[k] && !OutReady[k];
            if (in_xfer && (Select == 2'(k))) begin
                valid_d[k] = 1'b1;
                data_d[k]  = InData;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            valid_q <= '0;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

`ifdef DEMUX_J_ERROR_EN
    logic error_q;
    logic error_d;

    always_comb begin
        error_d = error_q || (in_xfer && (Select == 2'd3));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign Error = error_q;
`else
    assign Error = 1'b0;
`endif

    assign Output1  = data_q[0];
    assign Output2  = data_q[1];
    assign Output3  = data_q[2];
    assign OutValid = valid_q;

endmodule

// File: tb/tb_demux_j.sv
// tb/tb_demux_j.sv - self-checking bench for demux_j with a per-destination reference model
module tb_demux_j;

    logic        Clock;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] InData;
    logic [1:0]  Select;
    logic [31:0] Output1;
    logic [31:0] Output2;
    logic [31:0] Output3;
    logic [2:0]  OutValid;
    logic [2:0]  OutReady;
    logic        Error;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [31:0] m_data [3];
    bit          m_valid [3];
    bit          m_err;

    demux_j #(.N(32)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InData(InData), .Select(Select), .Output1(Output1), .Output2(Output2),
        .Output3(Output3), .OutValid(OutValid), .OutReady(OutReady), .Error(Error)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input logic [1:0] sel, input logic [2:0] ordy);
        if (sel == 2'd3) return 1'b1;
        return !m_valid[sel] || ordy[sel];
    endfunction

    // Reference model: a destination empties when taken, then fills if selected and accepted.
    always @(posedge Clock) begin
        if (Reset) begin
            for (int k = 0; k < 3; k++) begin
                m_valid[k] = 0;
                m_data[k]  = '0;
            end
            m_err = 0;
        end else begin
            bit rdy;
            rdy = model_ready(Select, OutReady);
            for (int k = 0; k < 3; k++) begin
                if (m_valid[k] && OutReady[k]) m_valid[k] = 0;
            end
            if (InValid && rdy) begin
                if (Select != 2'd3) begin
                    m_valid[Select] = 1;
                    m_data[Select]  = InData;
                end else begin
`ifdef DEMUX_J_ERROR_EN
                    m_err = 1;
`endif
                end
            end
        end
    end

    always @(negedge Clock) begin
        if (started) begin
            logic [31:0] outs [3];
            outs[0] = Output1;
            outs[1] = Output2;
            outs[2] = Output3;
            chk("model_inready", {63'd0, InReady}, {63'd0, model_ready(Select, OutReady)});
            chk("model_outvalid", {61'd0, OutValid}, {61'd0, m_valid[2], m_valid[1], m_valid[0]});
            chk("model_error", {63'd0, Error}, {63'd0, m_err});
            for (int k = 0; k < 3; k++) begin
                if (m_valid[k]) chk($sformatf("model_output%0d", k + 1), {32'd0, outs[k]}, {32'd0, m_data[k]});
            end
        end
    end

    task automatic drive(input bit rst, input bit iv, input logic [1:0] sel,
                         input logic [31:0] d, input logic [2:0] ordy);
        Reset    = rst;
        InValid  = iv;
        Select   = sel;
        InData   = d;
        OutReady = ordy;
        @(negedge Clock);
        #1;
    endtask

    task automatic next_edge();
        @(posedge Clock);
        #1;
    endtask

    bit err_exp;

    initial begin
`ifdef DEMUX_J_ERROR_EN
        err_exp = 1;
`else
        err_exp = 0;
`endif
        Reset = 1; InValid = 0; Select = 0; InData = 0; OutReady = 0;
        @(posedge Clock);
        #1;
        started = 1;
        drive(1, 1, 2'd0, 32'hFFFF_FFFF, 3'b111);
        next_edge();

        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("reset_outvalid", {61'd0, OutValid}, 64'd0);
        chk("reset_error", {63'd0, Error}, 64'd0);
        chk("reset_outputs", {Output1, Output3}, 64'd0);
        for (int s = 0; s < 4; s++) begin
            Select = 2'(s);
            #1;
            chk($sformatf("reset_inready_sel%0d", s), {63'd0, InReady}, 64'd1);
        end
        next_edge();

        drive(0, 1, 2'd1, 32'hDEAD_BEEF, 3'b000);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("first_outvalid", {61'd0, OutValid}, 64'h2);
        chk("first_output2", {32'd0, Output2}, 64'hDEAD_BEEF);
        chk("first_others", {Output1, Output3}, 64'd0);
        next_edge();

        drive(0, 1, 2'd0, 32'hA5A5_A5A5, 3'b000);
        next_edge();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 2'd0, 32'h1111_1111, 3'b000);
            chk("stall_inready", {63'd0, InReady}, 64'd0);
            chk("stall_output1", {32'd0, Output1}, 64'hA5A5_A5A5);
            next_edge();
        end
        drive(0, 1, 2'd0, 32'h1111_1111, 3'b001);
        chk("release_inready", {63'd0, InReady}, 64'd1);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b111);
        chk("release_output1", {32'd0, Output1}, 64'h1111_1111);
        chk("release_outvalid", {61'd0, OutValid}, 64'h3);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("drained_outvalid", {61'd0, OutValid}, 64'd0);
        next_edge();

        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 2'd2, 32'(i), 3'b100);
            if (i > 1) begin
                chk("stream_output3", {32'd0, Output3}, 64'(i - 1));
                chk("stream_valid3", {63'd0, OutValid[2]}, 64'd1);
            end
            next_edge();
        end
        drive(0, 0, 2'd2, 32'h0, 3'b100);
        chk("stream_output3_last", {32'd0, Output3}, 64'd8);
        chk("stream_valid3_last", {63'd0, OutValid[2]}, 64'd1);
        next_edge();

        drive(0, 1, 2'd3, 32'h1234_5678, 3'b000);
        chk("illegal_inready", {63'd0, InReady}, 64'd1);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("illegal_outvalid", {61'd0, OutValid}, 64'd0);
        chk("illegal_error", {63'd0, Error}, {63'd0, err_exp});
        next_edge();

        drive(0, 1, 2'd0, 32'h0000_1111, 3'b000);
        next_edge();
        drive(0, 1, 2'd2, 32'h0000_3333, 3'b000);
        next_edge();
        drive(0, 1, 2'd0, 32'h0000_AAAA, 3'b101);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("concurrent_outvalid", {61'd0, OutValid}, 64'h1);
        chk("concurrent_output1", {32'd0, Output1}, 64'hAAAA);
        next_edge();

        drive(0, 1, 2'd1, 32'h0000_2222, 3'b000);
        next_edge();
        drive(0, 1, 2'd2, 32'h0000_4444, 3'b000);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("full_outvalid", {61'd0, OutValid}, 64'h7);
        next_edge();
        drive(1, 1, 2'd0, 32'h5555_5555, 3'b111);
        next_edge();
        drive(0, 0, 2'd0, 32'h0, 3'b000);
        chk("midreset_outvalid", {61'd0, OutValid}, 64'd0);
        chk("midreset_error", {63'd0, Error}, 64'd0);
        chk("midreset_outputs12", {Output1, Output2}, 64'd0);
        chk("midreset_output3", {32'd0, Output3}, 64'd0);
        next_edge();

        for (int i = 0; i < 60; i++) begin
            drive(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 3'($urandom_range(0, 7)));
            next_edge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
